int_reg_read: RTL and testbench



---
 rtl/int_reg_read.sv | 96 +++++++++
 tb/tb_int_reg_read.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/int_reg_read.sv
// int_reg_read: register-read stage with integer register file, WB bypass and EX pipeline register
package int_reg_read_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
  } src_reg_t;
  typedef struct packed {
    src_reg_t             rs1;
    src_reg_t             rs2;
    logic [REG_IDX_W-1:0] rd;
    logic [6:0]           op;
  } decode_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    decode_t     decode;
  } issued_instr_t;
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } int_arch_reg_wb_t;
endpackage

module int_reg_read
  import int_reg_read_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int NUM_REGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_stall,
  input  issued_instr_t    i_instr,
  input  int_arch_reg_wb_t i_int_reg_wb,
  output logic             o_stall,
  output issued_instr_t    o_instr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic [31:0]      i_log_fd
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic byp1, byp2;
  src_reg_t rs1, rs2;

  assign o_stall = i_stall;
  assign rs1 = i_instr.decode.rs1;
  assign rs2 = i_instr.decode.rs2;

  // operand read: x0/invalid read as zero, same-cycle WB data wins over the array
  always_comb begin
    byp1 = rs1.valid && rs1.idx != '0 && i_int_reg_wb.valid && i_int_reg_wb.idx == rs1.idx;
    byp2 = rs2.valid && rs2.idx != '0 && i_int_reg_wb.valid && i_int_reg_wb.idx == rs2.idx;
    rs1_val = (!rs1.valid || rs1.idx == '0) ? '0 : byp1 ? i_int_reg_wb.data : regs[rs1.idx];
    rs2_val = (!rs2.valid || rs2.idx == '0) ? '0 : byp2 ? i_int_reg_wb.data : regs[rs2.idx];
  end

  // architectural writes commit regardless of stall/flush; x0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_int_reg_wb.valid && i_int_reg_wb.idx != '0) begin
      regs[i_int_reg_wb.idx] <= i_int_reg_wb.data;
    end
  end

  // output slot toward EX: flush clears, stall holds (operands are not refreshed while held)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr    <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
    end else if (i_flush) begin
      o_instr    <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
    end else if (!i_stall) begin
      o_instr    <= i_instr;
      o_rs1_data <= rs1_val;
      o_rs2_data <= rs2_val;
    end
  end

`ifndef SYNTHESIS
  // simulation trace of every accepted cycle
  always @(posedge i_clk) begin
    if (i_rst_n && !i_stall && i_log_fd != 0)
      $display("[RF ] v=%0d pc=%h rs1=x%0d %h rs2=x%0d %h byp1=%0d byp2=%0d",
               i_instr.valid, i_instr.pc, rs1.idx, rs1_val, rs2.idx, rs2_val, byp1, byp2);
  end
`endif
endmodule

// File: tb/tb_int_reg_read.sv
// tb_int_reg_read: directed checks of register file, bypass, stall, flush and reset
module tb_int_reg_read;
  import int_reg_read_pkg::*;
  logic clk = 0, clk_en = 0;
  logic rst_n, flush, stall;
  issued_instr_t instr, o_instr, held;
  int_arch_reg_wb_t wb;
  logic o_stall;
  logic [31:0] rs1_data, rs2_data;
  int passed = 0, total = 0;

  int_reg_read dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
    .i_instr(instr), .i_int_reg_wb(wb), .o_stall(o_stall), .o_instr(o_instr),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data), .i_log_fd(32'd0)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic issued_instr_t mk(input logic [31:0] pc, input logic v1, input logic [4:0] i1,
                                       input logic v2, input logic [4:0] i2);
    issued_instr_t t;
    t = '0;
    t.valid = 1'b1;
    t.pc = pc;
    t.decode.rs1 = '{v1, i1};
    t.decode.rs2 = '{v2, i2};
    t.decode.rd = 5'd1;
    t.decode.op = 7'h33;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] idx, input logic [31:0] d);
    wb = '{1'b1, idx, d};
    instr = '0;
    tick();
    wb = '0;
  endtask

  initial begin
    rst_n = 1; flush = 0; stall = 0; instr = '0; wb = '0;
    #2 rst_n = 0;
    #1;
    chk("rst_instr", 64'(o_instr), 64'd0);
    chk("rst_rs1", 64'(rs1_data), 64'd0);
    chk("rst_rs2", 64'(rs2_data), 64'd0);
    clk_en = 1;
    #12 rst_n = 1;
    for (int i = 1; i < 32; i++) begin
      instr = mk(32'h100 + 32'(i) * 4, 1'b1, 5'(i), 1'b1, 5'(32 - i));
      tick();
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) chk($sformatf("rst_read_x%0d", i), {rs1_data, rs2_data}, 64'd0);
      else begin passed++; total++; end
    end
    chk("capture_instr", 64'(o_instr), 64'(mk(32'h17C, 1'b1, 5'd31, 1'b1, 5'd1)));
    write(5'd5, 32'hDEADBEEF);
    instr = mk(32'h200, 1'b1, 5'd5, 1'b1, 5'd0);
    tick();
    chk("wr_rd_x5", 64'(rs1_data), 64'hDEADBEEF);
    chk("rd_x0_rs2", 64'(rs2_data), 64'd0);
    wb = '{1'b1, 5'd7, 32'h12345678};
    instr = mk(32'h204, 1'b1, 5'd7, 1'b1, 5'd7);
    tick();
    wb = '0;
    chk("byp_rs1", 64'(rs1_data), 64'h12345678);
    chk("byp_rs2", 64'(rs2_data), 64'h12345678);
    instr = mk(32'h208, 1'b1, 5'd7, 1'b1, 5'd5);
    tick();
    chk("arr_x7", 64'(rs1_data), 64'h12345678);
    chk("arr_x5", 64'(rs2_data), 64'hDEADBEEF);
    write(5'd9, 32'h55);
    wb = '{1'b1, 5'd0, 32'hFFFFFFFF};
    instr = mk(32'h20C, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    wb = '0;
    chk("x0_byp_rs1", 64'(rs1_data), 64'd0);
    chk("x0_byp_rs2", 64'(rs2_data), 64'd0);
    instr = mk(32'h210, 1'b0, 5'd9, 1'b1, 5'd9);
    tick();
    chk("inv_rs1", 64'(rs1_data), 64'd0);
    chk("x9_rs2", 64'(rs2_data), 64'h55);
    instr = mk(32'h214, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    chk("x0_after_wr", 64'(rs1_data), 64'd0);
    write(5'd3, 32'hA);
    held = mk(32'h300, 1'b1, 5'd3, 1'b1, 5'd9);
    instr = held;
    tick();
    chk("pre_stall_x3", 64'(rs1_data), 64'hA);
    stall = 1;
    #1 chk("o_stall_hi", 64'(o_stall), 64'd1);
    wb = '{1'b1, 5'd3, 32'hB};
    instr = mk(32'h304, 1'b1, 5'd5, 1'b1, 5'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall_hold_rs1_%0d", c), 64'(rs1_data), 64'hA);
      chk($sformatf("stall_hold_instr_%0d", c), 64'(o_instr), 64'(held));
    end
    stall = 0;
    wb = '0;
    #1 chk("o_stall_lo", 64'(o_stall), 64'd0);
    instr = mk(32'h308, 1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    chk("x3_after_stall", 64'(rs1_data), 64'hB);
    flush = 1;
    wb = '{1'b1, 5'd4, 32'h99};
    instr = mk(32'h400, 1'b1, 5'd5, 1'b1, 5'd7);
    tick();
    flush = 0;
    wb = '0;
    chk("flush_valid", 64'(o_instr.valid), 64'd0);
    chk("flush_instr", 64'(o_instr), 64'd0);
    chk("flush_rs1", 64'(rs1_data), 64'd0);
    chk("flush_rs2", 64'(rs2_data), 64'd0);
    instr = mk(32'h404, 1'b1, 5'd4, 1'b1, 5'd3);
    tick();
    chk("x4_after_flush", 64'(rs1_data), 64'h99);
    stall = 1;
    flush = 1;
    tick();
    flush = 0;
    chk("flush_over_stall", 64'(o_instr), 64'd0);
    stall = 0;
    instr = mk(32'h500, 1'b1, 5'd5, 1'b1, 5'd7);
    tick();
    stall = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_stall_instr", 64'(o_instr), 64'd0);
    chk("rst_stall_rs1", 64'(rs1_data), 64'd0);
    tick();
    rst_n = 1;
    stall = 0;
    tick();
    chk("rst_x5_cleared", 64'(rs1_data), 64'd0);
    chk("rst_x7_cleared", 64'(rs2_data), 64'd0);
    chk("post_rst_instr", 64'(o_instr), 64'(mk(32'h500, 1'b1, 5'd5, 1'b1, 5'd7)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
